lisp_heap_mem: RTL and testbench

//  Parametrised cons-cell heap memory: single-cycle tagged read port, two-beat cons allocator, and

---
 rtl/lisp_heap_mem.sv | 166 ++++++++++++++++
 tb/tb_lisp_heap_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lisp_heap_mem.sv
// Cons-cell heap memory sitting between the evaluator FSM and block RAM.
// A read port with one-cycle latency, a two-beat cons allocator and a
// guarded set-car/set-cdr port share one RAM write port. The low region
// [0, HEAP_START) is a write-protected constant ROM.
module lisp_heap_mem #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 12,
  parameter int                TAG_W      = 3,
  parameter int                DEPTH      = 256,
  parameter int                HEAP_START = 5,
  parameter logic [TAG_W-1:0]  TAG_CONS   = 3'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              cons_en,
  input  logic [DATA_W-1:0] cons_car,
  input  logic [DATA_W-1:0] cons_cdr,
  output logic              cons_busy,
  output logic              cons_done,
  output logic [DATA_W-1:0] cons_ptr,
  output logic              cons_err,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DATA_W-1:0] set_data,
  output logic              set_ready,
  output logic              set_err,
  output logic [ADDR_W:0]   heap_free
);

  localparam int MA = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] HSTART_L = (ADDR_W+1)'(HEAP_START);

  typedef enum logic {S_IDLE, S_CAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     heap_ptr_q, heap_ptr_d;
  logic [DATA_W-1:0]   car_q, car_d;
  logic [DATA_W-1:0]   ram_q [0:DEPTH-1];
  logic                rd_ready_q, rd_err_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                cons_done_q, cons_err_q;
  logic [DATA_W-1:0]   cons_ptr_q;
  logic                set_err_q;

  logic                fits, cons_accept, cons_reject, set_ok, rd_oob;
  logic                we;
  logic [MA-1:0]       waddr;
  logic [DATA_W-1:0]   wdata;

  // Preloaded constants in the ROM region; NIL lives at address 0.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    if (a == ADDR_W'(1))      w = DATA_W'(16'hBEEF);
    else if (a == ADDR_W'(2)) w = DATA_W'(16'hDEAD);
    else if (a == ADDR_W'(3)) w = DATA_W'(16'h0001);
    else if (a == ADDR_W'(4)) w = DATA_W'(16'h0002);
    return w;
  endfunction

  assign fits        = (heap_ptr_q + (ADDR_W+1)'(2)) <= DEPTH_L;
  assign cons_accept = (state_q == S_IDLE) & cons_en & fits;
  assign cons_reject = (state_q == S_IDLE) & cons_en & ~fits;
  assign set_ready   = set_en & (state_q == S_IDLE) & ~cons_accept;
  assign set_ok      = set_ready & ({1'b0, set_addr} >= HSTART_L) & ({1'b0, set_addr} < DEPTH_L);
  assign rd_oob      = {1'b0, rd_addr} >= DEPTH_L;

  // Allocator next state: cdr goes in on the first beat, car on the second.
  always_comb begin
    state_d    = state_q;
    heap_ptr_d = heap_ptr_q;
    car_d      = car_q;
    case (state_q)
      S_IDLE: begin
        if (cons_accept) begin
          car_d      = cons_car;
          heap_ptr_d = heap_ptr_q + (ADDR_W+1)'(1);
          state_d    = S_CAR;
        end
      end
      S_CAR: begin
        heap_ptr_d = heap_ptr_q + (ADDR_W+1)'(1);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single RAM write port: allocator beats take priority over the set port.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (rst_n) begin
      if (cons_accept) begin
        we    = 1'b1;
        waddr = heap_ptr_q[MA-1:0];
        wdata = cons_cdr;
      end else if (state_q == S_CAR) begin
        we    = 1'b1;
        waddr = heap_ptr_q[MA-1:0];
        wdata = car_q;
      end else if (set_ok) begin
        we    = 1'b1;
        waddr = set_addr[MA-1:0];
        wdata = set_data;
      end
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) ram_q[waddr] <= wdata;
  end

  // Control and result registers; reads see the pre-write (old) RAM word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      heap_ptr_q  <= HSTART_L;
      rd_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      cons_done_q <= 1'b0;
      cons_err_q  <= 1'b0;
      cons_ptr_q  <= '0;
      set_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      heap_ptr_q  <= heap_ptr_d;
      rd_ready_q  <= rd_req;
      rd_err_q    <= rd_req & rd_oob;
      if (rd_req) begin
        if (rd_oob)                        rd_data_q <= '0;
        else if ({1'b0, rd_addr} < HSTART_L) rd_data_q <= rom_word(rd_addr);
        else                               rd_data_q <= ram_q[rd_addr[MA-1:0]];
      end
      cons_done_q <= (state_q == S_CAR) | cons_reject;
      cons_err_q  <= cons_reject;
      if (state_q == S_CAR) cons_ptr_q <= {1'b0, TAG_CONS, heap_ptr_q[ADDR_W-1:0]};
      set_err_q   <= set_ready & ~set_ok;
    end
  end

  // Latched car word is data only; it needs no reset.
  always_ff @(posedge clk) begin
    car_q <= car_d;
  end

  assign rd_ready  = rd_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign cons_busy = (state_q == S_CAR);
  assign cons_done = cons_done_q;
  assign cons_ptr  = cons_ptr_q;
  assign cons_err  = cons_err_q;
  assign set_err   = set_err_q;
  assign heap_free = DEPTH_L - heap_ptr_q;

endmodule

// File: tb/tb_lisp_heap_mem.sv
// Bench for lisp_heap_mem built with a small heap (DEPTH=8) so that
// exhaustion is reachable after a single cons.
module tb_lisp_heap_mem;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          cons_en;
  logic [DW-1:0] cons_car;
  logic [DW-1:0] cons_cdr;
  logic          cons_busy;
  logic          cons_done;
  logic [DW-1:0] cons_ptr;
  logic          cons_err;
  logic          set_en;
  logic [AW-1:0] set_addr;
  logic [DW-1:0] set_data;
  logic          set_ready;
  logic          set_err;
  logic [AW:0]   heap_free;

  int n_chk  = 0;
  int n_fail = 0;

  lisp_heap_mem #(
    .DATA_W(16), .ADDR_W(12), .TAG_W(3), .DEPTH(8), .HEAP_START(5), .TAG_CONS(3'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err),
    .cons_en(cons_en), .cons_car(cons_car), .cons_cdr(cons_cdr), .cons_busy(cons_busy),
    .cons_done(cons_done), .cons_ptr(cons_ptr), .cons_err(cons_err),
    .set_en(set_en), .set_addr(set_addr), .set_data(set_data), .set_ready(set_ready),
    .set_err(set_err), .heap_free(heap_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_req  = 1'b1;
    rd_addr = a;
    step();
    rd_req  = 1'b0;
    chk({nm, "_rdy"}, 32'(rd_ready), 32'd1);
    chk({nm, "_data"}, 32'(rd_data), 32'(exp));
    chk({nm, "_err"}, 32'(rd_err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{12'd0,    16'h0000, 1'b0};
    vecs[1] = '{12'd1,    16'hBEEF, 1'b0};
    vecs[2] = '{12'd2,    16'hDEAD, 1'b0};
    vecs[3] = '{12'd3,    16'h0001, 1'b0};
    vecs[4] = '{12'd4,    16'h0002, 1'b0};
    vecs[5] = '{12'd8,    16'h0000, 1'b1};
    vecs[6] = '{12'hFFF,  16'h0000, 1'b1};

    rd_req = 0; rd_addr = '0; cons_en = 0; cons_car = '0; cons_cdr = '0;
    set_en = 0; set_addr = '0; set_data = '0;
    do_reset();

    // Reset state
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_busy", 32'(cons_busy), 0);
    chk("rst_done", 32'(cons_done), 0);
    chk("rst_ptr", 32'(cons_ptr), 0);
    chk("rst_cerr", 32'(cons_err), 0);
    chk("rst_serr", 32'(set_err), 0);
    chk("rst_free", 32'(heap_free), 3);

    // Back-to-back table reads: ROM constants and out-of-range addresses
    for (int i = 0; i < 7; i++) begin
      rd_req  = 1'b1;
      rd_addr = vecs[i].addr;
      step();
      chk($sformatf("tbl%0d_rdy", i), 32'(rd_ready), 1);
      chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(vecs[i].data));
      chk($sformatf("tbl%0d_err", i), 32'(rd_err), 32'(vecs[i].err));
    end
    rd_req = 1'b0;
    step();
    chk("rd_idle_rdy", 32'(rd_ready), 0);

    // Cons from reset: cdr at 5, car at 6, pointer addresses car
    cons_en = 1; cons_car = 16'h1111; cons_cdr = 16'h2222;
    step();
    cons_en = 0;
    chk("c1_busy", 32'(cons_busy), 1);
    chk("c1_done_early", 32'(cons_done), 0);
    step();
    chk("c1_done", 32'(cons_done), 1);
    chk("c1_err", 32'(cons_err), 0);
    chk("c1_ptr", 32'(cons_ptr), 32'h1006);
    chk("c1_busy_after", 32'(cons_busy), 0);
    chk("c1_free", 32'(heap_free), 1);
    step();
    chk("c1_done_pulse", 32'(cons_done), 0);
    rd("c1_cdr", 12'd5, 16'h2222);
    rd("c1_car", 12'd6, 16'h1111);

    // Mark word 7, then a cons that no longer fits must fail without writing
    set_en = 1; set_addr = 12'd7; set_data = 16'h7777;
    #1;
    chk("s7_ready", 32'(set_ready), 1);
    step();
    set_en = 0;
    chk("s7_err", 32'(set_err), 0);
    cons_en = 1; cons_car = 16'h3333; cons_cdr = 16'h4444;
    #1;
    chk("full_busy_in", 32'(cons_busy), 0);
    step();
    cons_en = 0;
    chk("full_done", 32'(cons_done), 1);
    chk("full_err", 32'(cons_err), 1);
    chk("full_ptr", 32'(cons_ptr), 32'h1006);
    chk("full_free", 32'(heap_free), 1);
    chk("full_busy", 32'(cons_busy), 0);
    step();
    chk("full_done_pulse", 32'(cons_done), 0);
    chk("full_err_pulse", 32'(cons_err), 0);
    rd("full_m7", 12'd7, 16'h7777);

    // Set port blocked by an allocating cons, then granted
    do_reset();
    cons_en = 1; cons_car = 16'hA1A1; cons_cdr = 16'hC2C2;
    set_en = 1; set_addr = 12'd6; set_data = 16'h5A5A;
    #1;
    chk("sb_ready0", 32'(set_ready), 0);
    step();
    cons_en = 0;
    #1;
    chk("sb_ready_car", 32'(set_ready), 0);
    step();
    chk("sb_cdone", 32'(cons_done), 1);
    chk("sb_ready1", 32'(set_ready), 1);
    step();
    set_en = 0;
    chk("sb_serr", 32'(set_err), 0);
    rd("sb_m6", 12'd6, 16'h5A5A);
    rd("sb_m5", 12'd5, 16'hC2C2);

    // Writes into ROM or past DEPTH are refused with a one-cycle set_err
    set_en = 1; set_addr = 12'd2; set_data = 16'h1234;
    #1;
    chk("rom_ready", 32'(set_ready), 1);
    step();
    set_en = 0;
    chk("rom_err", 32'(set_err), 1);
    step();
    chk("rom_err_pulse", 32'(set_err), 0);
    rd("rom_m2", 12'd2, 16'hDEAD);
    set_en = 1; set_addr = 12'd8; set_data = 16'h9999;
    step();
    set_en = 0;
    chk("oob_err", 32'(set_err), 1);
    set_en = 1; set_addr = 12'd4; set_data = 16'h9999;
    step();
    set_en = 0;
    chk("rom4_err", 32'(set_err), 1);
    rd("rom_m4", 12'd4, 16'h0002);

    // Read-first on a same-cycle write to the same address
    rd_req = 1; rd_addr = 12'd6;
    set_en = 1; set_addr = 12'd6; set_data = 16'h6666;
    step();
    rd_req = 0; set_en = 0;
    chk("rf_old", 32'(rd_data), 32'h5A5A);
    chk("rf_rdy", 32'(rd_ready), 1);
    rd("rf_new", 12'd6, 16'h6666);

    // Reset during CAR abandons the car write and rewinds the heap
    do_reset();
    cons_en = 1; cons_car = 16'hEEEE; cons_cdr = 16'hFFFF;
    step();
    cons_en = 0;
    chk("rc_busy", 32'(cons_busy), 1);
    chk("rc_free_mid", 32'(heap_free), 2);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rc_done", 32'(cons_done), 0);
    chk("rc_busy_after", 32'(cons_busy), 0);
    chk("rc_free", 32'(heap_free), 3);
    step();
    chk("rc_done_late", 32'(cons_done), 0);
    rd("rc_m6", 12'd6, 16'h6666);
    cons_en = 1; cons_car = 16'hABCD; cons_cdr = 16'hDCBA;
    step();
    cons_en = 0;
    step();
    chk("rc2_done", 32'(cons_done), 1);
    chk("rc2_ptr", 32'(cons_ptr), 32'h1006);
    rd("rc2_m6", 12'd6, 16'hABCD);
    rd("rc2_m5", 12'd5, 16'hDCBA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
